mac_operand_feeder: RTL and testbench

Sequencer that drives the MAC accumulator's operand side and collects its result. Given a layer type and two base addresses, it streams activation/weight pairs from single-cycle-latency RAMs into the MAC. It then issues the flush cycle and captures the MAC's one-cycle result pulse by timing. The result is presented on a valid/ready port to the layer controller, which writes it back to feature-map memory.

---
 rtl/mac_operand_feeder.sv | 110 +++++++++++
 tb/tb_mac_operand_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for the MAC: streams N act/wgt pairs from 1-cycle RAMs, flushes, captures the result.
// Optional build macro FEEDER_RELU_EN clamps negative captured results to zero.
module mac_operand_feeder #(
  parameter int ADDR_W   = 16,
  parameter int CONV_LEN = 25,
  parameter int FC_LEN   = 192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               layer,
  input  logic [ADDR_W-1:0]        act_base,
  input  logic [ADDR_W-1:0]        wgt_base,
  output logic                     busy,
  output logic [ADDR_W-1:0]        act_addr,
  output logic [ADDR_W-1:0]        wgt_addr,
  input  logic signed [15:0]       act_data,
  input  logic signed [15:0]       wgt_data,
  output logic                     mac_reset,
  output logic                     mac_enable,
  output logic [1:0]               mac_layer,
  output logic signed [15:0]       mac_a,
  output logic signed [15:0]       mac_b,
  input  logic signed [31:0]       mac_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [31:0]       res_data
);

  localparam int MAX_LEN = (CONV_LEN > FC_LEN) ? CONV_LEN : FC_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LEN - 1);
  localparam logic [CNT_W-1:0] FC_LAST   = CNT_W'(FC_LEN - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DRAIN, FLUSH, CAPTURE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   last;
  // RAM data lags the address by one cycle, so a data cycle follows every ADDR cycle
  logic               data_vld;
  logic signed [31:0] cap_val;

`ifdef FEEDER_RELU_EN
  assign cap_val = mac_out[31] ? 32'sd0 : mac_out;
`else
  assign cap_val = mac_out;
`endif

  assign mac_reset  = reset;
  assign mac_enable = data_vld | (state == FLUSH);
  assign mac_a      = data_vld ? act_data : 16'sd0;
  assign mac_b      = data_vld ? wgt_data : 16'sd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      data_vld  <= 1'b0;
      busy      <= 1'b0;
      act_addr  <= '0;
      wgt_addr  <= '0;
      mac_layer <= 2'd0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      data_vld <= (state == ADDR);
      case (state)
        IDLE: begin
          if (start && layer != 2'd3) begin
            mac_layer <= layer;
            act_addr  <= act_base;
            wgt_addr  <= wgt_base;
            cnt       <= '0;
            last      <= (layer == 2'd2) ? FC_LAST : CONV_LAST;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (cnt == last) begin
            state <= DRAIN;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            act_addr <= act_addr + ADDR_W'(1);
            wgt_addr <= wgt_addr + ADDR_W'(1);
          end
        end
        DRAIN: state <= FLUSH;
        FLUSH: state <= CAPTURE;
        CAPTURE: begin
          // Captured by timing: a genuine zero sum is still delivered
          res_data  <= cap_val;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder with behavioural RAMs, a behavioural MAC and a dot-product reference.
module tb_mac_operand_feeder;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         layer;
  logic [15:0]        act_base, wgt_base;
  logic               busy;
  logic [15:0]        act_addr, wgt_addr;
  logic signed [15:0] act_data, wgt_data;
  logic               mac_reset, mac_enable;
  logic [1:0]         mac_layer;
  logic signed [15:0] mac_a, mac_b;
  logic signed [31:0] mac_out;
  logic               res_valid, res_ready;
  logic signed [31:0] res_data;

  mac_operand_feeder dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer),
    .act_base(act_base), .wgt_base(wgt_base), .busy(busy),
    .act_addr(act_addr), .wgt_addr(wgt_addr),
    .act_data(act_data), .wgt_data(wgt_data),
    .mac_reset(mac_reset), .mac_enable(mac_enable), .mac_layer(mac_layer),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // single-cycle-latency RAMs
  logic signed [15:0] act_mem [0:65535];
  logic signed [15:0] wgt_mem [0:65535];
  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    wgt_data <= wgt_mem[wgt_addr];
  end

  // MAC: accumulates N products, emits the sum for one cycle after its N+1th enable
  int mac_acc = 0;
  int mac_cnt = 0;
  always @(posedge clk) begin
    int n;
    n = (mac_layer == 2'd2) ? 192 : 25;
    if (mac_reset) begin
      mac_acc = 0; mac_cnt = 0; mac_out <= 32'sd0;
    end else begin
      mac_out <= 32'sd0;
      if (mac_enable) begin
        if (mac_cnt == n) begin
          mac_out <= mac_acc; mac_acc = 0; mac_cnt = 0;
        end else begin
          mac_acc = mac_acc + int'(mac_a) * int'(mac_b);
          mac_cnt++;
        end
      end
    end
  end

  typedef struct {int d; int sc; int n;} sb_t;
  sb_t q[$];

  function automatic int ref_res(input logic [1:0] l, input logic [15:0] ab, input logic [15:0] wb);
    int s = 0;
    int n = (l == 2'd2) ? 192 : 25;
    logic [15:0] ai, wi;
    for (int i = 0; i < n; i++) begin
      ai = ab + 16'(i);
      wi = wb + 16'(i);
      s = s + int'(act_mem[ai]) * int'(wgt_mem[wi]);
    end
`ifdef FEEDER_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // ready generator: random acceptance unless the bench is holding it low
  bit hold_low = 1'b0;
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: latency on rising res_valid, data on handshake
  initial begin
    bit prev_v = 1'b0;
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset) prev_v = 1'b0;
      else begin
        if (res_valid && !prev_v) begin
          if (q.size() == 0) chk("unexpected_valid", 1, 0);
          else chk("valid_latency", cyc - q[0].sc, q[0].n + 4);
        end
        if (res_valid && res_ready) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk("res_data", res_data, e.d);
          end
        end
        prev_v = res_valid;
      end
    end
  end

  task automatic fill(input logic [15:0] ab, input logic [15:0] wb, input int mode);
    logic [15:0] ai, wi;
    for (int i = 0; i < 192; i++) begin
      ai = ab + 16'(i);
      wi = wb + 16'(i);
      case (mode)
        0: begin act_mem[ai] = 16'(i + 1); wgt_mem[wi] = 16'sd2; end
        1: begin act_mem[ai] = -16'sd1;    wgt_mem[wi] = 16'sd300; end
        2: begin act_mem[ai] = 16'sd0;     wgt_mem[wi] = 16'($urandom); end
        default: begin act_mem[ai] = 16'($urandom); wgt_mem[wi] = 16'($urandom); end
      endcase
    end
  endtask

  task automatic do_start(input logic [1:0] l, input logic [15:0] ab, input logic [15:0] wb);
    sb_t e;
    start = 1'b1; layer = l; act_base = ab; wgt_base = wb;
    e.sc = cyc; e.n = (l == 2'd2) ? 192 : 25; e.d = ref_res(l, ab, wb);
    @(posedge clk); #1;
    start = 1'b0;
    if (l != 2'd3) q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("done_timeout", k >= 600, 0);
  endtask

  task automatic run(input logic [1:0] l, input logic [15:0] ab, input logic [15:0] wb);
    do_start(l, ab, wb);
    @(negedge clk);
    chk("busy_cycle1", busy, 1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_act_addr"}, act_addr, 0);
    chk({tag, "_wgt_addr"}, wgt_addr, 0);
    chk({tag, "_mac_enable"}, mac_enable, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
    chk({tag, "_mac_layer"}, mac_layer, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
  endtask

  initial begin
    logic [15:0] ab, wb, a0;
    logic [1:0]  l;
    logic signed [31:0] saved;
    int k;
    reset = 1'b1; start = 1'b0; layer = 2'd0; act_base = '0; wgt_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("mac_reset_follows", mac_reset, 1);
    @(posedge clk); #1 reset = 1'b0;

    // conv ramp: 2*(1+..+25) = 650
    fill(16'h0100, 16'h0200, 0);
    chk("ref_conv", ref_res(2'd0, 16'h0100, 16'h0200), 650);
    run(2'd0, 16'h0100, 16'h0200);

    // FC: 192 * (-1*300)
    fill(16'h1000, 16'h2000, 1);
`ifdef FEEDER_RELU_EN
    chk("ref_fc", ref_res(2'd2, 16'h1000, 16'h2000), 0);
`else
    chk("ref_fc", ref_res(2'd2, 16'h1000, 16'h2000), -57600);
`endif
    run(2'd2, 16'h1000, 16'h2000);

    // true zero sum is still delivered
    fill(16'h3000, 16'h4000, 2);
    run(2'd1, 16'h3000, 16'h4000);

    // backpressure with a duplicate start during the hold
    fill(16'h5000, 16'h6000, 3);
    hold_low = 1'b1;
    do_start(2'd0, 16'h5000, 16'h6000);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk("hold_valid_timeout", k >= 100, 0);
    saved = res_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res_data", res_data, saved);
      chk("hold_busy", busy, 1);
      if (i == 4) begin
        start = 1'b1; layer = 2'd0; act_base = 16'h0100; wgt_base = 16'h0200;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    hold_low = 1'b0;
    wait_done();
    repeat (4) begin
      @(negedge clk);
      chk("dup_start_busy", busy, 0);
      chk("dup_start_valid", res_valid, 0);
    end

    // illegal layer is dropped
    a0 = act_addr;
    do_start(2'd3, 16'h7000, 16'h7100);
    repeat (4) begin
      @(negedge clk);
      chk("illegal_busy", busy, 0);
      chk("illegal_act_addr", act_addr, a0);
      chk("illegal_mac_enable", mac_enable, 0);
    end

    // address wrap
    fill(16'hFFF0, 16'h0800, 3);
    do_start(2'd0, 16'hFFF0, 16'h0800);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("wrap_act_addr", act_addr, 16'(32'hFFF0 + i));
      chk("wrap_wgt_addr", wgt_addr, 16'h0800 + 16'(i));
    end
    wait_done();
    @(negedge clk);

    // reset in cycle 10 of a run, then a clean run
    fill(16'h0900, 16'h0A00, 3);
    do_start(2'd1, 16'h0900, 16'h0A00);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("midrun_reset");
    run(2'd1, 16'h0900, 16'h0A00);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      l  = 2'($urandom_range(0, 2));
      ab = 16'($urandom);
      wb = 16'($urandom);
      fill(ab, wb, 3);
      run(l, ab, wb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
